// File: rtl/seg7_scan_drv.sv
// Time-multiplexed 4-digit 7-segment driver: scans hh:mm one digit per slot,
// latches a whole frame at the wrap, and handles colon, blink and leading-zero blanking.
module seg7_scan_drv #(
    parameter int REFRESH_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    input  logic       tick_1hz_i,
    input  logic [3:0] blink_mask_i,
    input  logic       lzb_en_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [3:0] an_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRES_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]     pres_q, pres_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   shd_q, shd_d;
    logic              ph_q, ph_d;
    logic              vld_q, vld_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic              wrap;
    logic              slot_end;
    logic [3:0]        cur_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        slot_end  = (pres_q == PRES_LAST);
        wrap      = slot_end && (idx_q == 2'd3);
        pres_d    = slot_end ? '0 : pres_q + PW'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        // Digits are captured only at the frame boundary so a frame never mixes old and new time.
        shd_d     = wrap ? {digit3_i, digit2_i, digit1_i, digit0_i} : shd_q;
        vld_d     = vld_q | wrap;
        ph_d      = ph_q ^ tick_1hz_i;
        cur_digit = shd_q[idx_q];

        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (vld_q) begin
            an_d  = 4'b0001 << idx_q;
            seg_d = seg_decode(cur_digit);
            if ((idx_q == 2'd3) && (cur_digit == 4'd0) && lzb_en_i) begin
                seg_d = '0;
            end
            if (blink_mask_i[idx_q] && !ph_q) begin
                seg_d = '0;
            end
            // In set mode the colon stays lit so the blinking digits stand out.
            if (idx_q == 2'd2) begin
                dp_d = (blink_mask_i == 4'd0) ? ph_q : 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pres_q <= PRES_LAST;
            idx_q  <= 2'd3;
            shd_q  <= '0;
            ph_q   <= 1'b1;
            vld_q  <= 1'b0;
            seg_q  <= '0;
            dp_q   <= 1'b0;
            an_q   <= '0;
        end else begin
            pres_q <= pres_d;
            idx_q  <= idx_d;
            shd_q  <= shd_d;
            ph_q   <= ph_d;
            vld_q  <= vld_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign dp_o  = dp_q;
    assign an_o  = an_q;

endmodule
